// File: rtl/apple_placement_ctrl.sv
// Apple relocation sequencer: on a synchronized goodColl rising edge, draws random
// candidates, scans the snake body, and commits a free cell (optional APPLE_BORDER_EXCL_EN).
module apple_placement_ctrl #(
    parameter int unsigned MAX_LEN     = 50,
    parameter int unsigned MAX_RETRY   = 8,
    parameter logic [7:0]  RESET_APPLE = 8'hC5,
    localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    goodColl,
    input  logic [3:0]              randX,
    input  logic [3:0]              randY,
    input  logic [MAX_LEN-1:0][7:0] body,
    input  logic [LEN_W-1:0]        length,
    output logic [7:0]              apple_cord,
    output logic                    apple_valid,
    output logic                    busy,
    output logic                    place_done,
    output logic                    place_fail,
    output logic [7:0]              retry_count
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SCAN,
        S_HIT,
        S_COMMIT,
        S_FAIL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [7:0]       r_cand;
    logic [7:0]       w_cand_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [7:0]       r_retry;
    logic [7:0]       w_retry_nxt;
    logic [7:0]       r_apple;
    logic [7:0]       w_apple_nxt;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_fail;

    logic             w_rise;
    logic [LEN_W-1:0] w_eff_len;
    logic [7:0]       w_sample;
    logic             w_border;
    logic             w_last;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_eff_len = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
    assign w_sample  = {randX, randY};
    // Last live segment reached; also covers length shrinking below idx mid-scan.
    assign w_last    = ((LEN_W + 1)'(r_idx) + (LEN_W + 1)'(1)) >= (LEN_W + 1)'(w_eff_len);

`ifdef APPLE_BORDER_EXCL_EN
    assign w_border = (randX == 4'h0) || (randX == 4'hF) || (randY == 4'h0) || (randY == 4'hF);
`else
    assign w_border = 1'b0;
`endif

    // goodColl synchronizer plus history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= goodColl;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cand  <= 8'h00;
            r_idx   <= '0;
            r_retry <= 8'h00;
            r_apple <= RESET_APPLE;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_idx   <= w_idx_nxt;
            r_retry <= w_retry_nxt;
            r_apple <= w_apple_nxt;
            r_valid <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_COMMIT);
            r_fail  <= (w_state_nxt == S_FAIL);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_idx_nxt   = r_idx;
        w_retry_nxt = r_retry;
        w_apple_nxt = r_apple;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_SAMPLE;
                    w_retry_nxt = 8'h00;
                end
            end
            S_SAMPLE: begin
                w_cand_nxt  = w_sample;
                w_retry_nxt = r_retry + 8'h01;
                w_idx_nxt   = '0;
                if ((w_sample == r_apple) || w_border) begin
                    w_state_nxt = S_HIT;
                end else if (w_eff_len == '0) begin
                    w_state_nxt = S_COMMIT;
                end else begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (body[r_idx] == r_cand) begin
                    w_state_nxt = S_HIT;
                end else if (w_last) begin
                    w_state_nxt = S_COMMIT;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            S_HIT: begin
                if (r_retry == 8'(MAX_RETRY)) begin
                    w_state_nxt = S_FAIL;
                end else begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_COMMIT: begin
                w_apple_nxt = r_cand;
                w_state_nxt = S_IDLE;
            end
            S_FAIL: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign apple_cord  = r_apple;
    assign apple_valid = r_valid;
    assign busy        = r_busy;
    assign place_done  = r_done;
    assign place_fail  = r_fail;
    assign retry_count = r_retry;

endmodule

// File: tb/tb_apple_placement_ctrl.sv
// Randomized/directed bench for apple_placement_ctrl against a transaction-level
// schedule model of the placement search.
module tb_apple_placement_ctrl;

    localparam int unsigned MAX_LEN   = 50;
    localparam int unsigned MAX_RETRY = 8;
    localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1);
`ifdef APPLE_BORDER_EXCL_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    goodColl;
    logic [3:0]              randX;
    logic [3:0]              randY;
    logic [MAX_LEN-1:0][7:0] body;
    logic [LEN_W-1:0]        length;
    logic [7:0]              apple_cord;
    logic                    apple_valid;
    logic                    busy;
    logic                    place_done;
    logic                    place_fail;
    logic [7:0]              retry_count;

    apple_placement_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .goodColl    (goodColl),
        .randX       (randX),
        .randY       (randY),
        .body        (body),
        .length      (length),
        .apple_cord  (apple_cord),
        .apple_valid (apple_valid),
        .busy        (busy),
        .place_done  (place_done),
        .place_fail  (place_fail),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_apple;
    logic [7:0] m_body [MAX_LEN];
    int         m_len;
    logic [7:0] cands [MAX_RETRY];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_len();
        return (m_len > int'(MAX_LEN)) ? int'(MAX_LEN) : m_len;
    endfunction

    function automatic bit on_border(input logic [7:0] c);
        return BORDER_EN && (c[7:4] == 4'h0 || c[7:4] == 4'hF || c[3:0] == 4'h0 || c[3:0] == 4'hF);
    endfunction

    task automatic apply_body();
        for (int i = 0; i < int'(MAX_LEN); i++) body[i] = m_body[i];
        length = LEN_W'(m_len);
    endtask

    task automatic set_cands(input logic [7:0] first, input logic [7:0] rest);
        cands[0] = first;
        for (int i = 1; i < int'(MAX_RETRY); i++) cands[i] = rest;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            randX = 4'($urandom);
            randY = 4'($urandom);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(apple_valid), 32'd1);
            chk("idle_cord", 32'(apple_cord), 32'(m_apple));
            chk("idle_done", 32'(place_done), 32'd0);
            chk("idle_fail", 32'(place_fail), 32'd0);
        end
    endtask

    // Schedule each attempt from the placement rules, then drive/check cycle by cycle.
    // Offsets k count clock edges after goodColl is raised; the first SAMPLE is at k=3.
    task automatic place(input int gc_hold, input int second_at);
        int         samp_at [MAX_RETRY];
        int         n_att;
        int         c_edge;
        int         t;
        int         scanned;
        int         k_end;
        bit         ok;
        bit         hit;
        bit         drove;
        logic [7:0] old_apple;
        logic [7:0] new_apple;
        old_apple = m_apple;
        t = 3;
        ok = 1'b0;
        n_att = 0;
        c_edge = 0;
        for (int a = 0; a < int'(MAX_RETRY); a++) begin
            samp_at[a] = t;
            n_att = a + 1;
            hit = 1'b0;
            scanned = 0;
            if (cands[a] == m_apple || on_border(cands[a])) begin
                hit = 1'b1;
            end else begin
                scanned = eff_len();
                for (int j = 0; j < eff_len(); j++) begin
                    if (m_body[j] == cands[a]) begin
                        hit = 1'b1;
                        scanned = j + 1;
                        break;
                    end
                end
            end
            if (!hit) begin
                ok = 1'b1;
                c_edge = t + scanned + 1;
                break;
            end
            if (a == int'(MAX_RETRY) - 1) c_edge = t + scanned + 2;
            t = t + scanned + 2;
        end
        new_apple = ok ? cands[n_att-1] : old_apple;
        k_end = c_edge + 2;
        if (gc_hold + 3 > k_end) k_end = gc_hold + 3;
        if (second_at > 0 && second_at + 5 > k_end) k_end = second_at + 5;
        goodColl = 1'b1;
        for (int k = 1; k <= k_end; k++) begin
            tick();
            goodColl = (k < gc_hold) || (second_at > 0 && k >= second_at && k < second_at + 2);
            drove = 1'b0;
            for (int a = 0; a < n_att; a++) begin
                if (k == samp_at[a]) begin
                    {randX, randY} = cands[a];
                    drove = 1'b1;
                end
            end
            if (!drove) begin
                randX = 4'($urandom);
                randY = 4'($urandom);
            end
            chk($sformatf("busy_k%0d", k), 32'(busy), 32'(k >= 3 && k <= c_edge));
            chk($sformatf("valid_k%0d", k), 32'(apple_valid), 32'(!(k >= 3 && k <= c_edge)));
            chk($sformatf("done_k%0d", k), 32'(place_done), 32'(k == c_edge && ok));
            chk($sformatf("fail_k%0d", k), 32'(place_fail), 32'(k == c_edge && !ok));
            chk($sformatf("cord_k%0d", k), 32'(apple_cord), 32'((k <= c_edge) ? old_apple : new_apple));
            if (k > c_edge) chk($sformatf("retry_k%0d", k), 32'(retry_count), 32'(n_att));
        end
        goodColl = 1'b0;
        m_apple = new_apple;
    endtask

    initial begin
        reset    = 1'b0;
        goodColl = 1'b0;
        randX    = 4'h0;
        randY    = 4'h0;
        m_apple  = 8'hC5;
        for (int i = 0; i < int'(MAX_LEN); i++) m_body[i] = 8'(8'h80 + i);
        m_body[0] = 8'h11;
        m_body[1] = 8'h12;
        m_body[2] = 8'h13;
        m_len = 3;
        apply_body();

        // Reset state, then quiet idle with goodColl low
        repeat (3) tick();
        chk("rst_cord", 32'(apple_cord), 32'hC5);
        chk("rst_valid", 32'(apple_valid), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_retry", 32'(retry_count), 32'd0);
        reset = 1'b1;
        idle_check(10);

        // Single hit on body[1], then a free cell
        set_cands(8'h12, 8'h68);
        place(1, 0);
        idle_check(3);

        // Clean placement: done 5 cycles after rise
        set_cands(8'h79, 8'h79);
        place(1, 0);
        idle_check(3);

        // Exhaustion on the head segment
        set_cands(8'h11, 8'h11);
        place(1, 0);
        idle_check(3);

        // Candidate equal to current apple counts as a hit
        set_cands(8'h79, 8'h24);
        place(1, 0);
        idle_check(3);

        // Second pulse during SCAN is dropped
        m_len = 10;
        apply_body();
        set_cands(8'h3C, 8'h3C);
        place(2, 6);
        idle_check(3);

        // goodColl held 20 cycles yields one placement
        m_len = 3;
        apply_body();
        set_cands(8'h4D, 8'h4D);
        place(20, 0);
        idle_check(5);

        // Empty body commits straight from SAMPLE
        m_len = 0;
        apply_body();
        set_cands(8'h4D, 8'h5E);
        place(1, 0);
        idle_check(3);

        // Length above MAX_LEN saturates; hit on the last slot
        m_len = 63;
        apply_body();
        set_cands(m_body[MAX_LEN-1], 8'h2B);
        place(1, 0);
        idle_check(3);

        // Border cell: eligible unless border exclusion is built in
        m_len = 3;
        apply_body();
        set_cands(8'h0A, 8'h77);
        place(1, 0);
        idle_check(3);

        // Randomized transactions
        for (int r = 0; r < 12; r++) begin
            int unsigned sel;
            for (int i = 0; i < int'(MAX_LEN); i++) m_body[i] = 8'($urandom);
            m_len = int'($urandom_range(0, 63));
            apply_body();
            for (int a = 0; a < int'(MAX_RETRY); a++) begin
                sel = $urandom_range(0, 9);
                if (sel < 5 && eff_len() > 0) cands[a] = m_body[$urandom_range(0, eff_len() - 1)];
                else if (sel < 6) cands[a] = m_apple;
                else cands[a] = 8'($urandom);
            end
            place(int'($urandom_range(1, 4)), 0);
            idle_check(3);
        end

        // Reset in the middle of a long scan
        for (int i = 0; i < int'(MAX_LEN); i++) m_body[i] = 8'(8'h80 + i);
        m_len = 40;
        apply_body();
        goodColl = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            goodColl = 1'b0;
            if (k == 3) {randX, randY} = 8'h3C;
            else {randX, randY} = 8'($urandom);
        end
        chk("midscan_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_cord", 32'(apple_cord), 32'hC5);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(apple_valid), 32'd1);
        chk("abort_done", 32'(place_done), 32'd0);
        chk("abort_retry", 32'(retry_count), 32'd0);
        tick();
        reset = 1'b1;
        m_apple = 8'hC5;
        idle_check(5);

        // Placement still works after the abort
        set_cands(8'h3C, 8'h3C);
        place(1, 0);
        idle_check(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
